// File: rtl/param_processor.sv
// Purpose : multi-cycle accumulator-style processor core (MV/MVI/ADD/SUB/AND/OR/MVNZ) with DW-bit datapath.
// Latency : 2 cycles for moves and the reserved opcode, 4 cycles for ALU ops, counted from the T0 cycle with run=1.
// Backpressure: none; run is sampled only in T0 and holding it high gives back-to-back fetches.
// Ports   : clk, reset_n (async active-low) | run, d_in (instruction in T0, immediate in MVI T1)
//           bus (internal bus, combinational) | done/illegal (one-cycle pulses) | z_flag (G == 0)
//           dbg_sel -> dbg_reg (R[dbg_sel], combinational) | reg_ir, reg_a, reg_g (register taps)
// DW must be >= 9 because the instruction occupies d_in[8:0]; NREG is tied to the 3-bit register fields.
module param_processor #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] bus,
  output logic          done,
  output logic          illegal,
  output logic          z_flag,
  input  logic [2:0]    dbg_sel,
  output logic [DW-1:0] dbg_reg,
  output logic [DW-1:0] reg_ir,
  output logic [DW-1:0] reg_a,
  output logic [DW-1:0] reg_g
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  state_t        state_q, state_d;
  logic [DW-1:0] r_q [NREG];
  logic [DW-1:0] ir_q, a_q, g_q, g_d;

  // Decoded controls
  logic ir_we, a_we, g_we, r_we;
  logic sel_din, sel_rx, sel_ry, sel_g;

  logic [2:0]    op, rx, ry;
  logic [DW-1:0] rx_val, ry_val;

  assign op     = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];
  assign rx_val = r_q[rx];
  assign ry_val = r_q[ry];

  // Control FSM: each state selects at most one bus driver.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    illegal = 1'b0;
    ir_we   = 1'b0;
    a_we    = 1'b0;
    g_we    = 1'b0;
    r_we    = 1'b0;
    sel_din = 1'b0;
    sel_rx  = 1'b0;
    sel_ry  = 1'b0;
    sel_g   = 1'b0;
    unique case (state_q)
      T0: begin
        ir_we = 1'b1;
        if (run) state_d = T1;
      end
      T1: begin
        state_d = T0;
        case (op)
          OP_MV: begin
            sel_ry = 1'b1;
            r_we   = 1'b1;
            done   = 1'b1;
          end
          OP_MVI: begin
            sel_din = 1'b1;
            r_we    = 1'b1;
            done    = 1'b1;
          end
          OP_MVNZ: begin
            // Ry is placed on the bus either way; only the write is conditional on G.
            sel_ry = 1'b1;
            r_we   = (g_q != '0);
            done   = 1'b1;
          end
          OP_RSVD: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
          default: begin
            sel_rx  = 1'b1;
            a_we    = 1'b1;
            state_d = T2;
          end
        endcase
      end
      T2: begin
        sel_ry  = 1'b1;
        g_we    = 1'b1;
        state_d = T3;
      end
      T3: begin
        sel_g   = 1'b1;
        r_we    = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  // AND-OR bus mux; with no select active the bus reads zero.
  assign bus = ({DW{sel_din}} & d_in)
             | ({DW{sel_rx}}  & rx_val)
             | ({DW{sel_ry}}  & ry_val)
             | ({DW{sel_g}}   & g_q);

  // ALU result; only consulted in T2, where op is always an ALU opcode.
  always_comb begin
    g_d = g_q;
    case (op)
      OP_ADD:  g_d = a_q + bus;
      OP_SUB:  g_d = a_q - bus;
      OP_AND:  g_d = a_q & bus;
      OP_OR:   g_d = a_q | bus;
      default: g_d = g_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q     <= d_in;
      if (a_we)  a_q      <= bus;
      if (g_we)  g_q      <= g_d;
      if (r_we)  r_q[rx]  <= bus;
    end
  end

  // G changes only through g_we, so deriving the flag from G keeps it in step with every G write.
  assign z_flag  = (g_q == '0);
  assign dbg_reg = r_q[dbg_sel];
  assign reg_ir  = ir_q;
  assign reg_a   = a_q;
  assign reg_g   = g_q;

endmodule

// File: tb/tb_param_processor.sv
module tb_param_processor;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [15:0] d_in;
  logic [15:0] bus;
  logic        done;
  logic        illegal;
  logic        z_flag;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_reg;
  logic [15:0] reg_ir;
  logic [15:0] reg_a;
  logic [15:0] reg_g;

  param_processor #(.DW(16), .NREG(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .d_in    (d_in),
    .bus     (bus),
    .done    (done),
    .illegal (illegal),
    .z_flag  (z_flag),
    .dbg_sel (dbg_sel),
    .dbg_reg (dbg_reg),
    .reg_ir  (reg_ir),
    .reg_a   (reg_a),
    .reg_g   (reg_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    int          lat;
    logic        ill;
    logic [2:0]  rd;
    logic [15:0] val;
    logic [15:0] g;
    logic        z;
  } vec_t;

  localparam int NV = 19;

  vec_t        tv [NV];
  logic [15:0] mdl [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_cnt = 0;
  int          done_cnt = 0;
  int          start_c [NV+1];
  int          end_c   [NV+1];
  int          dn_before [NV+1];
  int          dn_after  [NV+1];

  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {7'd0, op, x, y};
  endfunction

  function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] imm, input int lat,
                              input logic ill, input logic [2:0] rd, input logic [15:0] val,
                              input logic [15:0] g, input logic z);
    vec_t v;
    v.instr = instr; v.imm = imm; v.lat = lat; v.ill = ill;
    v.rd = rd; v.val = val; v.g = g; v.z = z;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Rotate the debug selector and compare against the bench register model.
  task automatic chk_dbg();
    dbg_sel = dbg_sel + 3'd1;
    #1;
    chk("dbg_reg", {16'd0, dbg_reg}, {16'd0, mdl[dbg_sel]});
  endtask

  // Runs one instruction; run stays high so consecutive calls fetch back-to-back.
  task automatic exec(input vec_t v, input int idx);
    int c0;
    dn_before[idx] = done_cnt;
    @(negedge clk);
    d_in = v.instr;
    run  = 1'b1;
    c0   = cyc_cnt;
    start_c[idx] = c0;
    chk("t0_done", {31'd0, done}, 32'd0);
    chk_dbg();
    @(negedge clk);
    d_in = v.imm;
    chk("t1_ir", {16'd0, reg_ir}, {16'd0, v.instr});
    while (done !== 1'b1 && (cyc_cnt - c0) < 6) begin
      chk("mid_illegal", {31'd0, illegal}, 32'd0);
      if ((cyc_cnt - c0) == 2)
        chk("t2_a", {16'd0, reg_a}, {16'd0, mdl[v.instr[5:3]]});
      chk_dbg();
      @(negedge clk);
      d_in = 16'hDEAD;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", cyc_cnt - c0 + 1, v.lat);
    chk("illegal", {31'd0, illegal}, {31'd0, v.ill});
    end_c[idx] = cyc_cnt;
    @(posedge clk);
    #1;
    mdl[v.rd] = v.val;
    dbg_sel = v.rd;
    #1;
    chk("rd_value", {16'd0, dbg_reg}, {16'd0, v.val});
    chk("g_value", {16'd0, reg_g}, {16'd0, v.g});
    chk("z_flag", {31'd0, z_flag}, {31'd0, v.z});
    dn_after[idx] = done_cnt;
  endtask

  initial begin
    tv[0]  = mk(enc(3'd1, 3'd0, 3'd0), 16'h0005, 2, 1'b0, 3'd0, 16'h0005, 16'h0000, 1'b1);
    tv[1]  = mk(enc(3'd1, 3'd1, 3'd0), 16'hFFFF, 2, 1'b0, 3'd1, 16'hFFFF, 16'h0000, 1'b1);
    tv[2]  = mk(enc(3'd2, 3'd0, 3'd1), 16'h5A5A, 4, 1'b0, 3'd0, 16'h0004, 16'h0004, 1'b0);
    tv[3]  = mk(enc(3'd1, 3'd0, 3'd0), 16'h1234, 2, 1'b0, 3'd0, 16'h1234, 16'h0004, 1'b0);
    tv[4]  = mk(enc(3'd3, 3'd0, 3'd0), 16'h5A5A, 4, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
    tv[5]  = mk(enc(3'd1, 3'd2, 3'd0), 16'hABCD, 2, 1'b0, 3'd2, 16'hABCD, 16'h0000, 1'b1);
    tv[6]  = mk(enc(3'd6, 3'd2, 3'd0), 16'h5A5A, 2, 1'b0, 3'd2, 16'hABCD, 16'h0000, 1'b1);
    tv[7]  = mk(enc(3'd1, 3'd3, 3'd0), 16'hF0F0, 2, 1'b0, 3'd3, 16'hF0F0, 16'h0000, 1'b1);
    tv[8]  = mk(enc(3'd1, 3'd4, 3'd0), 16'h0FF0, 2, 1'b0, 3'd4, 16'h0FF0, 16'h0000, 1'b1);
    tv[9]  = mk(enc(3'd4, 3'd3, 3'd4), 16'h5A5A, 4, 1'b0, 3'd3, 16'h00F0, 16'h00F0, 1'b0);
    tv[10] = mk(enc(3'd1, 3'd3, 3'd0), 16'hF0F0, 2, 1'b0, 3'd3, 16'hF0F0, 16'h00F0, 1'b0);
    tv[11] = mk(enc(3'd5, 3'd3, 3'd4), 16'h5A5A, 4, 1'b0, 3'd3, 16'hFFF0, 16'hFFF0, 1'b0);
    tv[12] = mk(enc(3'd6, 3'd5, 3'd4), 16'h5A5A, 2, 1'b0, 3'd5, 16'h0FF0, 16'hFFF0, 1'b0);
    tv[13] = mk(16'hA1F4,              16'h5A5A, 2, 1'b1, 3'd6, 16'h0000, 16'hFFF0, 1'b0);
    tv[14] = mk(enc(3'd0, 3'd7, 3'd3), 16'h5A5A, 2, 1'b0, 3'd7, 16'hFFF0, 16'hFFF0, 1'b0);
    tv[15] = mk(enc(3'd2, 3'd1, 3'd1), 16'h5A5A, 4, 1'b0, 3'd1, 16'hFFFE, 16'hFFFE, 1'b0);
    tv[16] = mk(enc(3'd0, 3'd2, 3'd2), 16'h5A5A, 2, 1'b0, 3'd2, 16'hABCD, 16'hFFFE, 1'b0);
    tv[17] = mk(enc(3'd3, 3'd4, 3'd3), 16'h5A5A, 4, 1'b0, 3'd4, 16'h1000, 16'h1000, 1'b0);
    tv[18] = mk(enc(3'd1, 3'd6, 3'd0), 16'h0000, 2, 1'b0, 3'd6, 16'h0000, 16'h1000, 1'b0);

    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;

    // Power-on reset state
    reset_n = 1'b0;
    run     = 1'b0;
    d_in    = 16'h0000;
    dbg_sel = 3'd0;
    #12;
    chk("rst_z", {31'd0, z_flag}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_bus", {16'd0, bus}, 32'd0);
    chk("rst_g", {16'd0, reg_g}, 32'd0);
    chk("rst_a", {16'd0, reg_a}, 32'd0);
    chk("rst_ir", {16'd0, reg_ir}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) exec(tv[i], i);

    // MVI, MVI, ADD back-to-back: done on cycles 2, 4 and 8
    chk("win0_cycles", end_c[2] - start_c[0] + 1, 8);
    chk("win0_dones", dn_after[2] - dn_before[0], 3);
    chk("win0_done_c2", end_c[0] - start_c[0] + 1, 2);
    chk("win0_done_c4", end_c[1] - start_c[0] + 1, 4);
    // MV, ADD, MV with run held high
    chk("win1_cycles", end_c[16] - start_c[14] + 1, 8);
    chk("win1_dones", dn_after[16] - dn_before[14], 3);

    // Reset asserted in T2 of an ADD
    @(negedge clk);
    d_in = enc(3'd2, 3'd0, 3'd1);
    run  = 1'b1;
    @(negedge clk);
    d_in = 16'h0000;
    @(negedge clk);
    chk("pre_rst_a", {16'd0, reg_a}, {16'd0, mdl[0]});
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_z", {31'd0, z_flag}, 32'd1);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_bus", {16'd0, bus}, 32'd0);
    chk("mrst_g", {16'd0, reg_g}, 32'd0);
    chk("mrst_a", {16'd0, reg_a}, 32'd0);
    chk("mrst_ir", {16'd0, reg_ir}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_sel = r[2:0];
      #0.25;
      chk("mrst_reg", {16'd0, dbg_reg}, 32'd0);
    end
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    run = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mrst_hold_done", {31'd0, done}, 32'd0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
    end
    // A 2-cycle MVI right after reset proves the FSM restarted in T0.
    exec(mk(enc(3'd1, 3'd1, 3'd0), 16'h0042, 2, 1'b0, 3'd1, 16'h0042, 16'h0000, 1'b1), NV);
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
